// File: rtl/mt_wr_sink.sv
// mt_wr_sink: White Rabbit fabric sink unpacked into a Mock Turtle word stream.
// Each data word is held for one data word, so the final word of a frame can be
// tagged last (and errored) once cyc falls. Words go through a show-ahead FIFO.
module mt_wr_sink #(
  parameter int unsigned g_fifo_depth = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        snk_cyc_i,
  input  logic        snk_stb_i,
  input  logic        snk_we_i,
  input  logic [1:0]  snk_adr_i,
  input  logic [1:0]  snk_sel_i,
  input  logic [15:0] snk_dat_i,
  output logic        snk_ack_o,
  output logic        snk_stall_o,
  output logic        snk_err_o,
  output logic        snk_rty_o,
  output logic [31:0] src_data_o,
  output logic        src_valid_o,
  output logic        src_first_o,
  output logic        src_last_o,
  output logic        src_error_o,
  input  logic        src_ready_i
);

  localparam int unsigned AW = $clog2(g_fifo_depth);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_IDLE   = 2'd1,
    ST_FRAME  = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  typedef struct packed {
    logic [15:0] data;
    logic        first;
    logic        last;
    logic        error;
  } entry_t;

  state_t        state;
  entry_t        mem [g_fifo_depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] free;

  logic [15:0]   hold_data;
  logic          hold_valid;
  logic          hold_odd;
  logic          first_pend;
  logic          err_flag;

  logic          accept;
  logic          data_wr;
  logic          stat_err;
  logic          pop;
  logic          full;
  logic          push;
  entry_t        push_entry;
  entry_t        head;

  // The held word will also need a FIFO slot, so it counts against free space.
  assign free        = CW'(g_fifo_depth) - count - CW'(hold_valid);
  assign full        = (count == CW'(g_fifo_depth));
  assign snk_stall_o = (free < CW'(3)) || ((state != ST_FRAME) && (state != ST_IDLE));
  assign accept      = snk_cyc_i && snk_stb_i && !snk_stall_o;
  assign data_wr     = accept && snk_we_i && (snk_adr_i == 2'd0);
  assign stat_err    = accept && snk_we_i && (snk_adr_i == 2'd2) && snk_dat_i[1];
  assign pop         = src_valid_o && src_ready_i;

  assign snk_err_o   = 1'b0;
  assign snk_rty_o   = 1'b0;

  // Show-ahead head; outputs read zero while the FIFO is empty.
  assign head        = mem[rd_ptr];
  assign src_valid_o = (count != '0);
  assign src_data_o  = src_valid_o ? {16'h0000, head.data} : 32'h0000_0000;
  assign src_first_o = src_valid_o && head.first;
  assign src_last_o  = src_valid_o && head.last;
  assign src_error_o = src_valid_o && head.error;

  // FIFO push: a new data word displaces the held one, or the flush drains it as last.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if ((state == ST_FRAME) && data_wr && hold_valid) begin
      push             = 1'b1;
      push_entry.data  = hold_data;
      push_entry.first = first_pend;
    end else if ((state == ST_FLUSH) && hold_valid && (!full || pop)) begin
      push             = 1'b1;
      push_entry.data  = hold_odd ? {hold_data[15:8], 8'h00} : hold_data;
      push_entry.first = first_pend;
      push_entry.last  = 1'b1;
      push_entry.error = err_flag;
    end
  end

  // FIFO storage, not reset; validity is tracked by count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Frame FSM, hold register, FIFO pointers and ack.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= ST_RESYNC;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      hold_odd   <= 1'b0;
      first_pend <= 1'b0;
      err_flag   <= 1'b0;
      snk_ack_o  <= 1'b0;
    end else begin
      snk_ack_o <= accept;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);

      case (state)
        ST_RESYNC: begin
          if (!snk_cyc_i) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (snk_cyc_i) begin
            state      <= ST_FRAME;
            first_pend <= 1'b1;
            err_flag   <= stat_err;
            hold_valid <= data_wr;
            if (data_wr) begin
              hold_data <= snk_dat_i;
              hold_odd  <= (snk_sel_i == 2'b10);
            end
          end
        end
        ST_FRAME: begin
          if (!snk_cyc_i) begin
            state <= ST_FLUSH;
          end else begin
            if (stat_err) begin
              err_flag <= 1'b1;
            end
            if (data_wr) begin
              hold_data  <= snk_dat_i;
              hold_odd   <= (snk_sel_i == 2'b10);
              hold_valid <= 1'b1;
              if (hold_valid) begin
                first_pend <= 1'b0;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (!hold_valid) begin
            state <= ST_IDLE;
          end else if (push) begin
            hold_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_RESYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_mt_wr_sink.sv
// Bench for mt_wr_sink: frames are described as word lists; a frame-level model
// derives the expected stream words, a monitor collects what the DUT emits.
`timescale 1ns/1ps
module tb_mt_wr_sink;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        snk_cyc_i;
  logic        snk_stb_i;
  logic        snk_we_i;
  logic [1:0]  snk_adr_i;
  logic [1:0]  snk_sel_i;
  logic [15:0] snk_dat_i;
  logic        snk_ack_o;
  logic        snk_stall_o;
  logic        snk_err_o;
  logic        snk_rty_o;
  logic [31:0] src_data_o;
  logic        src_valid_o;
  logic        src_first_o;
  logic        src_last_o;
  logic        src_error_o;
  logic        src_ready_i;

  int tests_run    = 0;
  int tests_failed = 0;
  int ack_cnt      = 0;
  int strobe_cnt   = 0;

  // Stream word as {data32, first, last, error}.
  logic [34:0] exp_q [$];
  logic [34:0] obs_q [$];

  // Frame under construction.
  logic [1:0]  f_adr [$];
  logic [1:0]  f_sel [$];
  logic        f_we  [$];
  logic [15:0] f_dat [$];

  mt_wr_sink #(.g_fifo_depth(16)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .snk_cyc_i   (snk_cyc_i),
    .snk_stb_i   (snk_stb_i),
    .snk_we_i    (snk_we_i),
    .snk_adr_i   (snk_adr_i),
    .snk_sel_i   (snk_sel_i),
    .snk_dat_i   (snk_dat_i),
    .snk_ack_o   (snk_ack_o),
    .snk_stall_o (snk_stall_o),
    .snk_err_o   (snk_err_o),
    .snk_rty_o   (snk_rty_o),
    .src_data_o  (src_data_o),
    .src_valid_o (src_valid_o),
    .src_first_o (src_first_o),
    .src_last_o  (src_last_o),
    .src_error_o (src_error_o),
    .src_ready_i (src_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: stream transfers and acks, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (src_valid_o && src_ready_i)
      obs_q.push_back({src_data_o, src_first_o, src_last_o, src_error_o});
    if (snk_ack_o)
      ack_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void add_word(input logic [1:0] adr, input logic we,
                                   input logic [1:0] sel, input logic [15:0] dat);
    f_adr.push_back(adr);
    f_we.push_back(we);
    f_sel.push_back(sel);
    f_dat.push_back(dat);
  endfunction

  // Frame-level model: data words in order, first/last by position, error if any
  // status word had bit 1, odd tail byte zeroed on the last word only.
  function automatic void model_frame();
    int nd = 0;
    int k  = 0;
    bit err = 1'b0;
    logic [15:0] d;
    foreach (f_dat[i]) begin
      if (f_we[i] && f_adr[i] == 2'd2 && f_dat[i][1]) err = 1'b1;
      if (f_we[i] && f_adr[i] == 2'd0) nd++;
    end
    foreach (f_dat[i]) begin
      if (f_we[i] && f_adr[i] == 2'd0) begin
        k++;
        d = f_dat[i];
        if (k == nd && f_sel[i] == 2'b10) d[7:0] = 8'h00;
        exp_q.push_back({16'h0000, d, (k == 1), (k == nd), (k == nd) && err});
      end
    end
  endfunction

  // Drive the built frame. mode 0: ready=1, 1: random ready, 2: ready=0 until
  // the sink has stalled 10 cycles. Ends one cyc-low cycle after the last word.
  task automatic drive_frame(input int mode, output int stalls, output int first_stall);
    int i = 0;
    int budget = 0;
    int acc = 0;
    int stall_run = 0;
    bit released = 1'b0;
    bit ok;
    model_frame();
    stalls = 0;
    first_stall = -1;
    snk_cyc_i = 1'b1;
    if (f_dat.size() == 0) begin
      snk_stb_i = 1'b0;
      @(posedge clk_i); #1;
    end
    while (i < f_dat.size()) begin
      snk_stb_i = 1'b1;
      snk_we_i  = f_we[i];
      snk_adr_i = f_adr[i];
      snk_sel_i = f_sel[i];
      snk_dat_i = f_dat[i];
      src_ready_i = (mode == 1) ? 1'($urandom_range(0, 1)) :
                    ((mode == 2 && !released) ? 1'b0 : 1'b1);
      @(negedge clk_i);
      ok = !snk_stall_o;
      if (!ok) begin
        stalls++;
        stall_run++;
        if (first_stall < 0) first_stall = acc;
        if (mode == 2 && stall_run >= 10) released = 1'b1;
      end
      @(posedge clk_i); #1;
      if (ok) begin
        i++;
        acc++;
      end
      budget++;
      if (budget > 5000) begin
        tests_run++;
        tests_failed++;
        $display("FAIL drive_frame timeout: accepted %0d of %0d words", i, f_dat.size());
        break;
      end
    end
    strobe_cnt += acc;
    snk_stb_i = 1'b0;
    snk_cyc_i = 1'b0;
    src_ready_i = (mode == 1) ? 1'($urandom_range(0, 1)) :
                  ((mode == 2 && !released) ? 1'b0 : 1'b1);
    @(posedge clk_i); #1;
    f_adr.delete(); f_we.delete(); f_sel.delete(); f_dat.delete();
  endtask

  task automatic drain(input int mode);
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 3000) begin
      src_ready_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk_i); #1;
      n++;
    end
    src_ready_i = 1'b1;
    repeat (4) begin @(posedge clk_i); #1; end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; snk_cyc_i = 1'b1; snk_stb_i = 1'b0; snk_we_i = 1'b0;
    snk_adr_i = 2'd0; snk_sel_i = 2'b11; snk_dat_i = 16'h0000; src_ready_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    tests_run++;
    if ({snk_ack_o, snk_stall_o, src_valid_o, src_first_o, src_last_o, src_error_o} !== 6'b010000) begin
      tests_failed++;
      $display("FAIL reset flags: ack/stall/valid/first/last/error=%b want 010000",
               {snk_ack_o, snk_stall_o, src_valid_o, src_first_o, src_last_o, src_error_o});
    end
    tests_run++;
    if (src_data_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset data: got %h want 00000000", src_data_o);
    end
    rst_n_i = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
    tests_run++;
    if (snk_stall_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL resync stall with cyc high: got %b want 1", snk_stall_o);
    end
    snk_cyc_i = 1'b0;
    @(posedge clk_i); #1;
    tests_run++;
    if ({snk_stall_o, snk_err_o, snk_rty_o} !== 3'b000) begin
      tests_failed++;
      $display("FAIL idle stall/err/rty: got %b want 000", {snk_stall_o, snk_err_o, snk_rty_o});
    end
    src_ready_i = 1'b1;
  endtask

  task automatic test_long_frame();
    int st, fs, a0;
    exp_q.delete(); obs_q.delete(); a0 = ack_cnt;
    add_word(2'd2, 1'b1, 2'b11, 16'h0000);
    for (int v = 1; v <= 50; v++) add_word(2'd0, 1'b1, 2'b11, 16'(v));
    drive_frame(0, st, fs);
    drain(0);
    tests_run++;
    if (st !== 0) begin tests_failed++; $display("FAIL long_frame stalls: got %0d want 0", st); end
    tests_run++;
    if (ack_cnt - a0 !== 51) begin tests_failed++; $display("FAIL long_frame acks: got %0d want 51", ack_cnt - a0); end
    tests_run++;
    if (obs_q.size() !== 50) begin tests_failed++; $display("FAIL long_frame count: got %0d want 50", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL long_frame word %0d: got %h/%b want %h/%b", i,
                 obs_q[i][34:3], obs_q[i][2:0], exp_q[i][34:3], exp_q[i][2:0]);
      end
    end
  endtask

  task automatic test_error_status();
    int st, fs;
    exp_q.delete(); obs_q.delete();
    add_word(2'd2, 1'b1, 2'b11, 16'h0002);
    for (int v = 0; v < 10; v++) add_word(2'd0, 1'b1, 2'b11, 16'($urandom));
    drive_frame(0, st, fs);
    drain(0);
    tests_run++;
    if (obs_q.size() !== 10) begin tests_failed++; $display("FAIL error_status count: got %0d want 10", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL error_status word %0d: got %h/%b want %h/%b", i,
                 obs_q[i][34:3], obs_q[i][2:0], exp_q[i][34:3], exp_q[i][2:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int st, fs, a0;
    exp_q.delete(); obs_q.delete(); a0 = ack_cnt;
    for (int v = 0; v < 30; v++) add_word(2'd0, 1'b1, 2'b11, 16'($urandom));
    drive_frame(2, st, fs);
    drain(0);
    tests_run++;
    if (fs !== 14) begin tests_failed++; $display("FAIL backpressure stall point: got %0d words want 14", fs); end
    tests_run++;
    if (ack_cnt - a0 !== 30) begin tests_failed++; $display("FAIL backpressure acks: got %0d want 30", ack_cnt - a0); end
    tests_run++;
    if (obs_q.size() !== 30) begin tests_failed++; $display("FAIL backpressure count: got %0d want 30", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL backpressure word %0d: got %h/%b want %h/%b", i,
                 obs_q[i][34:3], obs_q[i][2:0], exp_q[i][34:3], exp_q[i][2:0]);
      end
    end
  endtask

  task automatic test_single_and_tail();
    int st, fs, k;
    exp_q.delete(); obs_q.delete();
    add_word(2'd0, 1'b1, 2'b11, 16'hABCD);
    drive_frame(0, st, fs);
    // One of the cyc-low cycles has already elapsed: 2 to the push, 1 more to valid.
    for (k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      if (src_valid_o) break;
    end
    @(posedge clk_i); #1;
    tests_run++;
    if (k !== 2) begin tests_failed++; $display("FAIL single latency: got %0d cycles want 2", k); end
    add_word(2'd0, 1'b1, 2'b11, 16'h1111);
    add_word(2'd0, 1'b1, 2'b10, 16'h12FF);
    drive_frame(0, st, fs);
    drain(0);
    tests_run++;
    if (obs_q.size() !== 3) begin tests_failed++; $display("FAIL single_tail count: got %0d want 3", obs_q.size()); end
    tests_run++;
    if (obs_q.size() == 3 && obs_q[2] !== {32'h0000_1200, 3'b010}) begin
      tests_failed++;
      $display("FAIL tail word: got %h/%b want 00001200/010", obs_q[2][34:3], obs_q[2][2:0]);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL single_tail word %0d: got %h/%b want %h/%b", i,
                 obs_q[i][34:3], obs_q[i][2:0], exp_q[i][34:3], exp_q[i][2:0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int acc = 0;
    int n = 0;
    int bad = 0;
    int a0, st, fs;
    bit ok;
    exp_q.delete(); obs_q.delete(); a0 = ack_cnt;
    src_ready_i = 1'b0;
    snk_cyc_i = 1'b1;
    while (acc < 5 && n < 100) begin
      snk_stb_i = 1'b1; snk_we_i = 1'b1; snk_adr_i = 2'd0; snk_sel_i = 2'b11;
      snk_dat_i = 16'(acc + 1);
      @(negedge clk_i);
      ok = !snk_stall_o;
      @(posedge clk_i); #1;
      if (ok) acc++;
      n++;
    end
    rst_n_i = 1'b0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    for (int w = 6; w <= 20; w++) begin
      snk_dat_i = 16'(w);
      @(negedge clk_i);
      if (snk_stall_o !== 1'b1 || src_valid_o !== 1'b0) bad++;
      @(posedge clk_i); #1;
    end
    snk_stb_i = 1'b0; snk_cyc_i = 1'b0;
    repeat (2) begin @(posedge clk_i); #1; end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL reset_mid stall/valid: %0d bad cycles want 0", bad); end
    tests_run++;
    if (ack_cnt - a0 !== 5) begin tests_failed++; $display("FAIL reset_mid acks: got %0d want 5", ack_cnt - a0); end
    src_ready_i = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
    tests_run++;
    if (obs_q.size() !== 0) begin tests_failed++; $display("FAIL reset_mid output: got %0d words want 0", obs_q.size()); end
    for (int v = 0; v < 8; v++) add_word(2'd0, 1'b1, 2'b11, 16'($urandom));
    drive_frame(0, st, fs);
    drain(0);
    tests_run++;
    if (obs_q.size() !== 8) begin tests_failed++; $display("FAIL reset_mid next frame count: got %0d want 8", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL reset_mid word %0d: got %h/%b want %h/%b", i,
                 obs_q[i][34:3], obs_q[i][2:0], exp_q[i][34:3], exp_q[i][2:0]);
      end
    end
  endtask

  task automatic test_two_frames_oob();
    int st, fs, a0, s0;
    exp_q.delete(); obs_q.delete(); a0 = ack_cnt; s0 = strobe_cnt;
    for (int v = 0; v < 6; v++) begin
      add_word(2'd0, 1'b1, 2'b11, 16'(16'h0100 + v));
      if (v % 2 == 0) add_word(2'd1, 1'b1, 2'b11, 16'hD00D);
    end
    drive_frame(0, st, fs);
    add_word(2'd1, 1'b1, 2'b11, 16'hBEEF);
    for (int v = 0; v < 4; v++) add_word(2'd0, 1'b1, 2'b11, 16'(16'h0200 + v));
    add_word(2'd3, 1'b1, 2'b11, 16'hCAFE);
    drive_frame(0, st, fs);
    // A status error with no data is dropped and must not leak into the next frame.
    add_word(2'd2, 1'b1, 2'b11, 16'h0002);
    add_word(2'd1, 1'b1, 2'b11, 16'h5555);
    drive_frame(0, st, fs);
    add_word(2'd0, 1'b1, 2'b11, 16'h0301);
    add_word(2'd0, 1'b0, 2'b11, 16'h0302);
    add_word(2'd0, 1'b1, 2'b11, 16'h0303);
    drive_frame(0, st, fs);
    drain(0);
    tests_run++;
    if (ack_cnt - a0 !== strobe_cnt - s0) begin
      tests_failed++;
      $display("FAIL two_frames acks: got %0d want %0d", ack_cnt - a0, strobe_cnt - s0);
    end
    tests_run++;
    if (obs_q.size() !== 12) begin tests_failed++; $display("FAIL two_frames count: got %0d want 12", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL two_frames word %0d: got %h/%b want %h/%b", i,
                 obs_q[i][34:3], obs_q[i][2:0], exp_q[i][34:3], exp_q[i][2:0]);
      end
    end
  endtask

  task automatic test_random_frames();
    int st, fs, a0, s0, nw, r;
    exp_q.delete(); obs_q.delete(); a0 = ack_cnt; s0 = strobe_cnt;
    for (int f = 0; f < 10; f++) begin
      nw = $urandom_range(0, 24);
      for (int w = 0; w < nw; w++) begin
        r = $urandom_range(0, 9);
        case (r)
          0:       add_word(2'd1, 1'b1, 2'b11, 16'($urandom));
          1:       add_word(2'd3, 1'b1, 2'b11, 16'($urandom));
          2:       add_word(2'd2, 1'b1, 2'b11, 16'($urandom));
          3:       add_word(2'd0, 1'b0, 2'b11, 16'($urandom));
          default: add_word(2'd0, 1'b1, ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11, 16'($urandom));
        endcase
      end
      drive_frame(1, st, fs);
    end
    drain(1);
    tests_run++;
    if (ack_cnt - a0 !== strobe_cnt - s0) begin
      tests_failed++;
      $display("FAIL random acks: got %0d want %0d", ack_cnt - a0, strobe_cnt - s0);
    end
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL random count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL random word %0d: got %h/%b want %h/%b", i,
                 obs_q[i][34:3], obs_q[i][2:0], exp_q[i][34:3], exp_q[i][2:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_long_frame();
    test_error_status();
    test_backpressure();
    test_single_and_tail();
    test_reset_mid_frame();
    test_two_frames_oob();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
